// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: imemory port, execute redirect and decode valid/ready handshake.
// The master side is the fetch stage; the slave side is memory, execute and decode.
interface fetch_stage_if;
    logic [31:0] imem_address;
    logic [31:0] imem_read_write;
    logic [31:0] imem_data_in;
    logic [31:0] imem_data_out;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        f_valid;
    logic        f_ready;
    logic [31:0] f_pc;
    logic [31:0] f_insn;

    modport master (
        output imem_address, imem_read_write, imem_data_in, f_valid, f_pc, f_insn,
        input  imem_data_out, redirect_valid, redirect_pc, f_ready
    );

    modport slave (
        input  imem_address, imem_read_write, imem_data_in, f_valid, f_pc, f_insn,
        output imem_data_out, redirect_valid, redirect_pc, f_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, one outstanding imemory read, DEPTH-entry {pc, insn} FIFO to decode.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect raises sticky fetch_fault and halts issue.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0100_0000,
    parameter int unsigned DEPTH    = 3
) (
    input  logic          clock,
    input  logic          reset_n,
    fetch_stage_if.master bus
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic          fetch_fault
`endif
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    logic [31:0] pc_q, pc_d;
    logic        infl_v_q, infl_v_d;
    logic [31:0] infl_pc_q, infl_pc_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    ptr_t        wr_ptr_q, wr_ptr_d;
    cnt_t        count_q, count_d;
    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] insn_mem [DEPTH];

    logic        halted;
    logic        credit_ok;
    logic        issue;
    logic        push;
    logic        pop;
    logic        valid;
    logic [31:0] target;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q, fault_d;
    logic misaligned;

    assign misaligned  = bus.redirect_pc[1:0] != 2'b00;
    assign halted      = fault_q;
    assign target      = misaligned ? pc_q : bus.redirect_pc;
    assign fetch_fault = fault_q;
`else
    assign halted = 1'b0;
    assign target = {bus.redirect_pc[31:2], 2'b00};
`endif

    // The in-flight read already owns a FIFO slot, so a push can never find the FIFO full.
    assign credit_ok = (32'(count_q) + 32'(infl_v_q)) < DEPTH;
    assign issue     = credit_ok && !halted && !bus.redirect_valid;
    assign push      = infl_v_q && !bus.redirect_valid;
    assign valid     = reset_n && (count_q != '0);
    assign pop       = valid && bus.f_ready && !bus.redirect_valid;

    always_comb begin
        pc_d      = pc_q;
        infl_v_d  = infl_v_q;
        infl_pc_d = infl_pc_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_d   = fault_q;
`endif
        if (bus.redirect_valid) begin
            pc_d     = target;
            infl_v_d = 1'b0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misaligned) begin
                fault_d = 1'b1;
            end
`endif
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + cnt_t'(1);
                2'b01:   count_d = count_q - cnt_t'(1);
                default: count_d = count_q;
            endcase
            infl_v_d = issue;
            if (issue) begin
                infl_pc_d = pc_q;
                pc_d      = pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc_q      <= RESET_PC;
            infl_v_q  <= 1'b0;
            infl_pc_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q   <= 1'b0;
`endif
        end else begin
            pc_q      <= pc_d;
            infl_v_q  <= infl_v_d;
            infl_pc_q <= infl_pc_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q   <= fault_d;
`endif
        end
    end

    // Storage needs no reset: outputs are masked while empty or in reset.
    always_ff @(posedge clock) begin
        if (reset_n && push) begin
            pc_mem[wr_ptr_q]   <= infl_pc_q;
            insn_mem[wr_ptr_q] <= bus.imem_data_out;
        end
    end

    assign bus.imem_address    = reset_n ? pc_q : RESET_PC;
    assign bus.imem_read_write = '0;
    assign bus.imem_data_in    = '0;
    assign bus.f_valid         = valid;
    assign bus.f_pc            = reset_n ? pc_mem[rd_ptr_q] : '0;
    assign bus.f_insn          = reset_n ? insn_mem[rd_ptr_q] : '0;

endmodule
